ref_sched: RTL



---
 rtl/ref_sched_if.sv | 13 +
 rtl/ref_sched.sv | 56 +++++
 2 files changed

// File: rtl/ref_sched_if.sv
// ref_sched_if: refresh scheduler signals between CNT/FSB inputs and the RAM controller
interface ref_sched_if #(parameter int PENDW = 3);
  logic             RefClk;
  logic             BACT;
  logic             RAMCS;
  logic             RefAck;
  logic             RefReq;
  logic             RefUrgent;
  logic             RefOvf;
  logic [PENDW-1:0] Pend;
  modport master (input RefClk, BACT, RAMCS, RefAck, output RefReq, RefUrgent, RefOvf, Pend);
  modport slave  (output RefClk, BACT, RAMCS, RefAck, input RefReq, RefUrgent, RefOvf, Pend);
endinterface

// File: rtl/ref_sched.sv
// ref_sched: counts RefClk refresh obligations and issues a RefReq/RefAck handshake to RAM
module ref_sched #(
  parameter int PENDW  = 3,
  parameter int URGENT = 4
) (
  input  logic FCLK,
  input  logic nRESin,
  ref_sched_if.master bus
);
  typedef enum logic [1:0] {IDLE, DEFER, REQ, GAP} state_t;
  localparam logic [PENDW-1:0] MAXPEND = '1;
  localparam logic [PENDW-1:0] URG     = PENDW'(URGENT);
  state_t           state_q, state_d;
  logic [2:0]       sync_q;
  logic [PENDW-1:0] pend_q, pend_d;
  logic             urg_q, urg_d, ovf_q, ovf_d, req_q, req_d;
  logic             tick, ack, busy, inc;
  assign tick = sync_q[1] & ~sync_q[2];
  assign ack  = bus.RefAck & (state_q == REQ);
  assign busy = bus.BACT & bus.RAMCS;
  assign inc  = tick & ~ack;
  always_comb begin
    pend_d  = (inc & pend_q != MAXPEND) ? pend_q + 1'b1 :
              (ack & ~tick)             ? pend_q - 1'b1 : pend_q;
    ovf_d   = ovf_q | (inc & pend_q == MAXPEND);
    urg_d   = pend_d >= URG;
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (pend_q == '0) ? IDLE : (busy & ~urg_q) ? DEFER : REQ;
      DEFER:   state_d = (pend_q == '0) ? IDLE : (~busy | urg_q) ? REQ : DEFER;
      REQ:     state_d = ack ? GAP : REQ;
      default: state_d = IDLE;
    endcase
    req_d   = state_d == REQ;
  end
  always_ff @(posedge FCLK or negedge nRESin)
    if (!nRESin) begin
      sync_q  <= '0;
      pend_q  <= '0;
      urg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      req_q   <= 1'b0;
      state_q <= IDLE;
    end else begin
      sync_q  <= {sync_q[1:0], bus.RefClk};
      pend_q  <= pend_d;
      urg_q   <= urg_d;
      ovf_q   <= ovf_d;
      req_q   <= req_d;
      state_q <= state_d;
    end
  assign bus.RefReq    = req_q;
  assign bus.RefUrgent = urg_q;
  assign bus.RefOvf    = ovf_q;
  assign bus.Pend      = pend_q;
endmodule
